// File: rtl/sdfm_pkg.sv
// Shared constants and helpers for the sigma-delta filter array.
package sdfm_pkg;

    localparam int unsigned MAX_ORDER = 3;
    localparam int unsigned MAX_NCH   = 8;
    localparam int unsigned CALC_W    = 64;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Bitstream 1 -> +1, 0 -> -1.
    function automatic logic signed [1:0] dsd_to_signed(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

    // Arithmetic shift then clamp to the signed out_w range; caller sign-extends to CALC_W.
    function automatic logic signed [CALC_W-1:0] sat_shift(
        input logic signed [CALC_W-1:0] v,
        input logic        [4:0]        sh,
        input int unsigned              out_w
    );
        logic signed [CALC_W-1:0] s;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        s  = v >>> sh;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/sdfm_cic_core.sv
// One channel: CIC integrators, decimation counter, combs, formatting and pending result.
// SDFM_SETTLE_EN: suppress the first ORDER results after reset or enable.
module sdfm_cic_core
    import sdfm_pkg::*;
#(
    parameter int unsigned ORDER = 3,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dsd,
    input  logic             i_stb,
    input  logic             i_en,
    input  logic [7:0]       i_dec,
    input  logic [4:0]       i_sh,
    input  logic             i_ovf_clr,
    input  logic             i_grant,
    output logic             o_pend,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf
);

    logic signed [ACC_W-1:0]  r_integ [ORDER];
    logic signed [ACC_W-1:0]  r_dly   [ORDER];
    logic signed [ACC_W-1:0]  w_cin   [ORDER];
    logic signed [ACC_W-1:0]  w_comb;
    logic signed [ACC_W-1:0]  w_x;
    logic signed [CALC_W-1:0] w_sat;
    logic [7:0]               r_cnt;
    logic                     r_evt;
    logic                     w_deliver;
    logic                     r_pend;
    logic                     r_ovf;
    logic [OUT_W-1:0]         r_data;

    assign w_x   = ACC_W'(dsd_to_signed(i_dsd));
    assign w_sat = sat_shift(CALC_W'(w_comb), i_sh, OUT_W);

    always_comb begin
        logic signed [ACC_W-1:0] v;
        v = r_integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            w_cin[k] = v;
            v = v - r_dly[k];
        end
        w_comb = v;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < ORDER; k++) begin
                r_integ[k] <= '0;
                r_dly[k]   <= '0;
            end
            r_cnt <= '0;
            r_evt <= 1'b0;
        end else if (!i_en) begin
            for (int k = 0; k < ORDER; k++) begin
                r_integ[k] <= '0;
                r_dly[k]   <= '0;
            end
            r_cnt <= '0;
            r_evt <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            if (i_stb) begin
                r_integ[0] <= r_integ[0] + w_x;
                for (int k = 1; k < ORDER; k++) begin
                    r_integ[k] <= r_integ[k] + r_integ[k-1];
                end
                // >= lets a lowered ratio take effect without a counter overrun
                if (r_cnt >= i_dec) begin
                    r_cnt <= '0;
                    r_evt <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            if (r_evt) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_dly[k] <= w_cin[k];
                end
            end
        end
    end

`ifdef SDFM_SETTLE_EN
    localparam logic [1:0] SETTLE_N = 2'(ORDER);
    logic [1:0] r_settle;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_settle <= '0;
        end else if (!i_en) begin
            r_settle <= '0;
        end else if (r_evt && (r_settle != SETTLE_N)) begin
            r_settle <= r_settle + 2'd1;
        end
    end

    assign w_deliver = r_evt && (r_settle == SETTLE_N);
`else
    assign w_deliver = r_evt;
`endif

    // A grant in the same cycle pushes the old value, so that is not an overwrite.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= 1'b0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_deliver) begin
                r_data <= w_sat[OUT_W-1:0];
                r_pend <= 1'b1;
            end else if (i_grant) begin
                r_pend <= 1'b0;
            end
            if (w_deliver && r_pend && !i_grant) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_data = r_data;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/sdfm_filt_array.sv
// Multi-channel sigma-delta decimation filter array with round-robin result FIFO.
// SDFM_SETTLE_EN (see sdfm_cic_core) suppresses start-up transients per channel.
module sdfm_filt_array
    import sdfm_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned ORDER      = 3,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                     SYSCLK,
    input  logic                                     SYSRST,
    input  logic [NCH-1:0]                           sd_dsd_in,
    input  logic [NCH-1:0]                           sd_clk_in,
    input  logic [NCH-1:0]                           cfg_en,
    input  logic [7:0]                               cfg_dec,
    input  logic [4:0]                               cfg_sh,
    input  logic                                     ovf_clr,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OUT_W-1:0]                         out_data,
    output logic [((NCH > 1) ? clog2(NCH) : 1)-1:0]  out_ch,
    output logic [clog2(FIFO_DEPTH):0]               fifo_level,
    output logic [NCH-1:0]                           ovf_flag
);

    localparam int unsigned CH_W  = (NCH > 1) ? clog2(NCH) : 1;
    localparam int unsigned AW    = clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [NCH-1:0]   w_pend;
    logic [NCH-1:0]   w_grant;
    logic [OUT_W-1:0] w_data [NCH];
    logic             w_gnt_vld;
    logic [CH_W-1:0]  w_gnt_ch;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [CH_W-1:0]  r_ptr;
    logic [OUT_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]  r_mem_ch   [FIFO_DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LVL_W-1:0] r_level;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sdfm_cic_core #(
            .ORDER (ORDER),
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_core (
            .i_clk     (SYSCLK),
            .i_rst     (SYSRST),
            .i_dsd     (sd_dsd_in[i]),
            .i_stb     (sd_clk_in[i]),
            .i_en      (cfg_en[i]),
            .i_dec     (cfg_dec),
            .i_sh      (cfg_sh),
            .i_ovf_clr (ovf_clr),
            .i_grant   (w_grant[i]),
            .o_pend    (w_pend[i]),
            .o_data    (w_data[i]),
            .o_ovf     (ovf_flag[i])
        );
    end

    // Scan offsets high to low so the closest pending channel at/after the pointer wins.
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        idx       = 0;
        for (int j = int'(NCH) - 1; j >= 0; j--) begin
            idx = int'(r_ptr) + j;
            if (idx >= int'(NCH)) idx = idx - int'(NCH);
            if (w_pend[CH_W'(idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CH_W'(idx);
            end
        end
    end

    assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push = w_gnt_vld && !w_full;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_grant = '0;
        if (w_push) w_grant[w_gnt_ch] = 1'b1;
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_ptr <= '0;
        end else if (w_push) begin
            r_ptr <= (w_gnt_ch == CH_W'(NCH - 1)) ? '0 : w_gnt_ch + CH_W'(1);
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem_data[k] <= '0;
                r_mem_ch[k]   <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr] <= w_data[w_gnt_ch];
                r_mem_ch[r_wr]   <= w_gnt_ch;
                r_wr             <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = r_mem_data[r_rd];
    assign out_ch     = r_mem_ch[r_rd];
    assign fifo_level = r_level;

endmodule
